// File: rtl/noc_mesh.sv
// ROWS x COLS mesh of single-flit, XY-routed routers with one local inject and eject port per node.
// Each router holds one flit per input side and arbitrates every output with its own round-robin pointer.
module noc_mesh #(
    parameter int ROWS       = 3,
    parameter int COLS       = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ROWS*COLS-1:0]            inj_valid,
    input  logic [ROWS*COLS*DATA_WIDTH-1:0] inj_data,
    output logic [ROWS*COLS-1:0]            inj_ready,
    output logic [ROWS*COLS-1:0]            ej_valid,
    output logic [ROWS*COLS*DATA_WIDTH-1:0] ej_data,
    input  logic [ROWS*COLS-1:0]            ej_ready,
    output logic [ROWS*COLS-1:0]            err_drop
);
    localparam int NODES = ROWS * COLS;
    localparam int DW    = DATA_WIDTH;
    localparam int NPORT = 5;
    // Input sides and outputs share one numbering; output P_L is the eject register.
    localparam int P_L = 0;
    localparam int P_N = 1;
    localparam int P_E = 2;
    localparam int P_S = 3;
    localparam int P_W = 4;

    function automatic logic has_nbr(input int n, input int d);
        int r;
        int c;
        r = n / COLS;
        c = n % COLS;
        case (d)
            P_N:     return r > 0;
            P_E:     return c < COLS - 1;
            P_S:     return r < ROWS - 1;
            P_W:     return c > 0;
            default: return 1'b0;
        endcase
    endfunction

    // Index is clamped to the node itself at the mesh edge so it never leaves the array.
    function automatic int nbr(input int n, input int d);
        if (!has_nbr(n, d)) return n;
        case (d)
            P_N:     return n - COLS;
            P_E:     return n + 1;
            P_S:     return n + COLS;
            P_W:     return n - 1;
            default: return n;
        endcase
    endfunction

    function automatic int opp(input int d);
        case (d)
            P_N:     return P_S;
            P_S:     return P_N;
            P_E:     return P_W;
            P_W:     return P_E;
            default: return P_L;
        endcase
    endfunction

    function automatic logic [2:0] xy_route(input int n, input logic [7:0] hdr);
        logic [3:0] row_id;
        logic [3:0] col_id;
        row_id = 4'(n / COLS);
        col_id = 4'(n % COLS);
        if (hdr[3:0] > col_id)      return 3'(P_E);
        else if (hdr[3:0] < col_id) return 3'(P_W);
        else if (hdr[7:4] > row_id) return 3'(P_S);
        else if (hdr[7:4] < row_id) return 3'(P_N);
        else                        return 3'(P_L);
    endfunction

    logic [DW-1:0]    buf_data    [NODES][NPORT];
    logic [NPORT-1:0] buf_full    [NODES];
    logic [2:0]       rr_ptr      [NODES][NPORT];
    logic [DW-1:0]    ej_reg      [NODES];

    logic [2:0]       route       [NODES][NPORT];
    logic [NPORT-1:0] target_free [NODES];
    logic [NPORT-1:0] out_grant   [NODES];
    logic [2:0]       out_win     [NODES][NPORT];
    logic [DW-1:0]    out_data    [NODES][NPORT];
    logic [NPORT-1:0] drain       [NODES];
    logic [NPORT-1:0] load        [NODES];
    logic [DW-1:0]    load_data   [NODES][NPORT];
    logic [NODES-1:0] inj_fire;
    logic [NODES-1:0] inj_bad;

    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            inj_ready[n] = !buf_full[n][P_L];
            inj_fire[n]  = inj_valid[n] && inj_ready[n];
            inj_bad[n]   = ({1'b0, inj_data[n*DW + DW-1 -: 4]} >= 5'(ROWS)) ||
                           ({1'b0, inj_data[n*DW + DW-5 -: 4]} >= 5'(COLS));
            ej_data[n*DW +: DW] = ej_reg[n];
            for (int i = 0; i < NPORT; i++)
                route[n][i] = xy_route(n, buf_data[n][i][DW-1 -: 8]);
            // Targets are judged only on flags registered at cycle start: no pass-through.
            target_free[n][P_L] = !ej_valid[n];
            for (int d = 1; d < NPORT; d++)
                target_free[n][d] = has_nbr(n, d) && !buf_full[nbr(n, d)][opp(d)];
        end
    end

    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            for (int o = 0; o < NPORT; o++) begin
                logic       found;
                logic [2:0] win;
                int         idx;
                // NOTE: every combinational variable is given a default before any
                // conditional write, so no path can leave it holding a stale value (latch).
                found = 1'b0;
                win   = 3'(P_L);
                for (int k = 1; k <= NPORT; k++) begin
                    idx = (int'(rr_ptr[n][o]) + k) % NPORT;
                    if (!found && buf_full[n][idx] && route[n][idx] == 3'(o)) begin
                        found = 1'b1;
                        win   = 3'(idx);
                    end
                end
                out_grant[n][o] = found && target_free[n][o];
                out_win[n][o]   = win;
                out_data[n][o]  = '0;
                for (int i = 0; i < NPORT; i++)
                    if (win == 3'(i)) out_data[n][o] = buf_data[n][i];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            drain[n] = '0;
            for (int i = 0; i < NPORT; i++)
                for (int o = 0; o < NPORT; o++)
                    if (out_grant[n][o] && out_win[n][o] == 3'(i)) drain[n][i] = 1'b1;
            // Out-of-mesh destinations are accepted but never stored.
            load[n][P_L]      = inj_fire[n] && !inj_bad[n];
            load_data[n][P_L] = inj_data[n*DW +: DW];
            for (int d = 1; d < NPORT; d++) begin
                load[n][d]      = has_nbr(n, d) && out_grant[nbr(n, d)][opp(d)];
                load_data[n][d] = out_data[nbr(n, d)][opp(d)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < NODES; n++) begin
                buf_full[n] <= '0;
                ej_valid[n] <= 1'b0;
                ej_reg[n]   <= '0;
                err_drop[n] <= 1'b0;
                for (int o = 0; o < NPORT; o++) rr_ptr[n][o] <= 3'(P_L);
            end
        end else begin
            for (int n = 0; n < NODES; n++) begin
                buf_full[n] <= (buf_full[n] & ~drain[n]) | load[n];
                err_drop[n] <= inj_fire[n] && inj_bad[n];
                if (ej_valid[n] && ej_ready[n]) begin
                    ej_valid[n] <= 1'b0;
                end else if (out_grant[n][P_L]) begin
                    ej_valid[n] <= 1'b1;
                    ej_reg[n]   <= out_data[n][P_L];
                end
                for (int o = 0; o < NPORT; o++)
                    if (out_grant[n][o]) rr_ptr[n][o] <= out_win[n][o];
            end
        end
    end

    // NOTE: buffer payloads carry no reset; the full flags alone decide whether
    // a slot holds a flit, so clearing the data array would only add reset fan-out.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NODES; n++)
            for (int i = 0; i < NPORT; i++)
                if (load[n][i]) buf_data[n][i] <= load_data[n][i];
    end

endmodule

// File: tb/tb_noc_mesh.sv
// Bench for noc_mesh on a 3x3 mesh: directed scenarios plus random traffic checked
// against per source/destination FIFO expectations and XY hop-count latency.
module tb_noc_mesh;
    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int DW    = 32;
    localparam int NODES = ROWS * COLS;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NODES-1:0]      inj_valid;
    logic [NODES*DW-1:0]   inj_data;
    logic [NODES-1:0]      inj_ready;
    logic [NODES-1:0]      ej_valid;
    logic [NODES*DW-1:0]   ej_data;
    logic [NODES-1:0]      ej_ready;
    logic [NODES-1:0]      err_drop;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    typedef struct packed {
        int            node;
        logic [DW-1:0] data;
        int            cyc;
    } ev_t;

    ev_t           log_q [$];
    logic [DW-1:0] exp_q [NODES*NODES][$];

    noc_mesh #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .inj_valid(inj_valid),
        .inj_data (inj_data),
        .inj_ready(inj_ready),
        .ej_valid (ej_valid),
        .ej_data  (ej_data),
        .ej_ready (ej_ready),
        .err_drop (err_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Record every eject handshake half a cycle before the edge that completes it.
    always @(negedge clk) begin
        for (int n = 0; n < NODES; n++) begin
            if (rst && ej_valid[n] && ej_ready[n]) begin
                ev_t e;
                e.node = n;
                e.data = ej_data[n*DW +: DW];
                e.cyc  = cycle;
                log_q.push_back(e);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    function automatic logic [DW-1:0] mk(input int dr, input int dc, input int src, input int seq);
        return {4'(dr), 4'(dc), 8'(src), 16'(seq)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input int node, input logic [DW-1:0] flit, output int acc, output bit ok);
        int w = 0;
        inj_valid[node]          = 1'b1;
        inj_data[node*DW +: DW]  = flit;
        while (!inj_ready[node] && w < 50) begin
            tick();
            w++;
        end
        ok = inj_ready[node];
        if (ok) tick();
        acc = cycle;
        inj_valid[node] = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        inj_valid = '0;
        inj_data  = '0;
        ej_ready  = '1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (ej_valid !== '0) begin tests_failed++; $display("FAIL reset_ej_valid_in_reset: got %b expected 0", ej_valid); end
        tests_run++;
        if (ej_data !== '0) begin tests_failed++; $display("FAIL reset_ej_data: got %h expected 0", ej_data); end
        rst = 1'b1;
        tick();
        tests_run++;
        if (inj_ready !== '1) begin tests_failed++; $display("FAIL reset_inj_ready: got %b expected all ones", inj_ready); end
        tests_run++;
        if (ej_valid !== '0) begin tests_failed++; $display("FAIL reset_ej_valid: got %b expected 0", ej_valid); end
        tests_run++;
        if (err_drop !== '0) begin tests_failed++; $display("FAIL reset_err_drop: got %b expected 0", err_drop); end
    endtask

    // One flit, all eject ports ready: exactly one delivery, at the XY distance + 1.
    task automatic test_path(input string name, input int src, input int dr, input int dc, input logic [DW-1:0] flit);
        int acc;
        bit ok;
        int hops;
        hops = ((dr > src / COLS) ? dr - src / COLS : src / COLS - dr) +
               ((dc > src % COLS) ? dc - src % COLS : src % COLS - dc);
        log_q.delete();
        ej_ready = '1;
        inject(src, flit, acc, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL %s_accept: got not accepted expected accepted", name); end
        repeat (12) tick();
        tests_run++;
        if (log_q.size() != 1) begin tests_failed++; $display("FAIL %s_count: got %0d ejects expected 1", name, log_q.size()); end
        if (log_q.size() > 0) begin
            tests_run++;
            if (log_q[0].node != dr * COLS + dc) begin tests_failed++; $display("FAIL %s_node: got %0d expected %0d", name, log_q[0].node, dr * COLS + dc); end
            tests_run++;
            if (log_q[0].data !== flit) begin tests_failed++; $display("FAIL %s_data: got %h expected %h", name, log_q[0].data, flit); end
            tests_run++;
            if (log_q[0].cyc - acc != hops + 1) begin tests_failed++; $display("FAIL %s_latency: got %0d expected %0d", name, log_q[0].cyc - acc, hops + 1); end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        bit ok;
        int n_ok = 0;
        log_q.delete();
        ej_ready    = '1;
        ej_ready[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inject(0, mk(0, 2, 0, 16'h100 + i), acc, ok);
            if (ok) n_ok++;
        end
        tests_run++;
        if (n_ok != 4) begin tests_failed++; $display("FAIL bp_accept: got %0d accepted expected 4", n_ok); end
        repeat (10) tick();
        tests_run++;
        if (inj_ready[0] !== 1'b0) begin tests_failed++; $display("FAIL bp_inj_ready: got %b expected 0", inj_ready[0]); end
        tests_run++;
        if (ej_valid[2] !== 1'b1) begin tests_failed++; $display("FAIL bp_held_valid: got %b expected 1", ej_valid[2]); end
        tests_run++;
        if (ej_data[2*DW +: DW] !== mk(0, 2, 0, 16'h100)) begin
            tests_failed++; $display("FAIL bp_held_data: got %h expected %h", ej_data[2*DW +: DW], mk(0, 2, 0, 16'h100));
        end
        tests_run++;
        if (log_q.size() != 0) begin tests_failed++; $display("FAIL bp_no_eject: got %0d ejects expected 0", log_q.size()); end
        ej_ready[2] = 1'b1;
        repeat (15) tick();
        tests_run++;
        if (log_q.size() != 4) begin tests_failed++; $display("FAIL bp_count: got %0d expected 4", log_q.size()); end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            tests_run++;
            if (log_q[i].node != 2 || log_q[i].data !== mk(0, 2, 0, 16'h100 + i)) begin
                tests_failed++;
                $display("FAIL bp_order_%0d: got node %0d data %h expected node 2 data %h", i, log_q[i].node, log_q[i].data, mk(0, 2, 0, 16'h100 + i));
            end
        end
    endtask

    // Nodes 0 and 6 both target node 3; node 3's eject arbiter must alternate N/S.
    task automatic test_contention();
        log_q.delete();
        ej_ready = '1;
        for (int r = 0; r < 4; r++) begin
            int w = 0;
            while (!(inj_ready[0] && inj_ready[6]) && w < 50) begin
                tick();
                w++;
            end
            tests_run++;
            if (!(inj_ready[0] && inj_ready[6])) begin tests_failed++; $display("FAIL cont_ready_%0d: got %b expected both ready", r, {inj_ready[0], inj_ready[6]}); end
            inj_valid[0]        = 1'b1;
            inj_valid[6]        = 1'b1;
            inj_data[0 +: DW]   = mk(1, 0, 0, r);
            inj_data[6*DW +: DW] = mk(1, 0, 6, r);
            tick();
            inj_valid = '0;
        end
        repeat (25) tick();
        tests_run++;
        if (log_q.size() != 8) begin tests_failed++; $display("FAIL cont_count: got %0d expected 8", log_q.size()); end
        for (int j = 0; j < 8 && j < log_q.size(); j++) begin
            int src = (j % 2 == 0) ? 0 : 6;
            tests_run++;
            if (log_q[j].node != 3 || log_q[j].data !== mk(1, 0, src, j / 2)) begin
                tests_failed++;
                $display("FAIL cont_order_%0d: got node %0d data %h expected node 3 data %h", j, log_q[j].node, log_q[j].data, mk(1, 0, src, j / 2));
            end
        end
    endtask

    task automatic test_invalid_dst();
        int acc;
        bit ok;
        log_q.delete();
        ej_ready = '1;
        inject(1, mk(3, 0, 1, 16'h77), acc, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL inv_accept: got not accepted expected accepted"); end
        tests_run++;
        if (err_drop !== NODES'(2)) begin tests_failed++; $display("FAIL inv_err_pulse: got %b expected %b", err_drop, NODES'(2)); end
        tick();
        tests_run++;
        if (err_drop !== '0) begin tests_failed++; $display("FAIL inv_err_clear: got %b expected 0", err_drop); end
        repeat (8) tick();
        tests_run++;
        if (log_q.size() != 0 || ej_valid !== '0) begin tests_failed++; $display("FAIL inv_no_eject: got %0d ejects valid %b expected none", log_q.size(), ej_valid); end
        tests_run++;
        if (inj_ready !== '1) begin tests_failed++; $display("FAIL inv_ready: got %b expected all ones", inj_ready); end
    endtask

    task automatic test_reset_midflight();
        int acc;
        bit ok;
        ej_ready    = '1;
        ej_ready[4] = 1'b0;
        inject(4, mk(1, 1, 4, 16'h99), acc, ok);
        inject(0, mk(2, 2, 0, 16'h98), acc, ok);
        tests_run++;
        if (ej_valid[4] !== 1'b1) begin tests_failed++; $display("FAIL mid_held: got %b expected 1", ej_valid[4]); end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (ej_valid !== '0 || inj_ready !== '1) begin
            tests_failed++; $display("FAIL mid_async_clear: got valid %b ready %b expected 0 and all ones", ej_valid, inj_ready);
        end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        ej_ready = '1;
        log_q.delete();
        repeat (10) tick();
        tests_run++;
        if (log_q.size() != 0) begin tests_failed++; $display("FAIL mid_discarded: got %0d ejects expected 0", log_q.size()); end
    endtask

    task automatic test_random();
        logic [DW-1:0] pend   [NODES];
        bit            pend_v [NODES];
        bit            acc    [NODES];
        int            seq      = 0;
        int            injected = 0;
        int            w        = 0;
        int            left     = 0;
        log_q.delete();
        for (int q = 0; q < NODES * NODES; q++) exp_q[q].delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int n = 0; n < NODES; n++) begin
                if (!pend_v[n] && cyc < 300 && $urandom_range(0, 2) == 0) begin
                    pend[n]   = mk($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), n, seq);
                    seq++;
                    pend_v[n] = 1'b1;
                end
                inj_valid[n]         = pend_v[n];
                inj_data[n*DW +: DW] = pend[n];
                acc[n]               = pend_v[n] && inj_ready[n];
            end
            ej_ready = NODES'($urandom);
            tick();
            for (int n = 0; n < NODES; n++) begin
                if (acc[n]) begin
                    int dst = int'(pend[n][31:28]) * COLS + int'(pend[n][27:24]);
                    exp_q[n * NODES + dst].push_back(pend[n]);
                    pend_v[n] = 1'b0;
                    injected++;
                end
            end
        end
        inj_valid = '0;
        ej_ready  = '1;
        while (log_q.size() < injected && w < 2000) begin
            tick();
            w++;
        end
        repeat (5) tick();
        tests_run++;
        if (log_q.size() != injected) begin tests_failed++; $display("FAIL rand_count: got %0d expected %0d", log_q.size(), injected); end
        foreach (log_q[j]) begin
            int            src = int'(log_q[j].data[23:16]);
            int            dst = log_q[j].node;
            logic [DW-1:0] exp = '0;
            tests_run++;
            if (src < NODES && exp_q[src * NODES + dst].size() > 0) exp = exp_q[src * NODES + dst].pop_front();
            if (log_q[j].data !== exp) begin
                tests_failed++; $display("FAIL rand_flit_%0d: got %h at node %0d expected %h", j, log_q[j].data, dst, exp);
            end
        end
        for (int q = 0; q < NODES * NODES; q++) left += exp_q[q].size();
        tests_run++;
        if (left != 0) begin tests_failed++; $display("FAIL rand_lost: got %0d undelivered expected 0", left); end
    endtask

    initial begin
        test_reset();
        test_path("single_path", 0, 2, 2, 32'h2200ABCD);
        test_path("self", 4, 1, 1, 32'h11CAFE5A);
        test_path("west_north", 8, 0, 0, 32'h00123456);
        test_backpressure();
        test_contention();
        test_invalid_dst();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
